// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Shared definitions for the I2S TX and RX channels: channel state
//   encoding, sample word width and bit-counter width.
package i2s_pkg;

  localparam int I2S_WORD_W   = 32;
  localparam int I2S_BITCNT_W = 5;

  typedef enum logic {
    I2S_TX_IDLE = 1'b0,
    I2S_TX_RUN  = 1'b1
  } i2s_tx_state_e;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen
//   SCK generator for the I2S transmitter. Counts clk_i cycles up to div_i,
//   then wraps and toggles SCK. rise_o/fall_o flag the cycle in which SCK is
//   about to go 0->1 / 1->0, so they line up with the registered SCK edge.
// Ports
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   en_i     run enable; low clears the divider and parks SCK low
//   div_i    SCK half-period minus 1, in clk_i cycles
//   sck_o    registered SCK
//   rise_o   SCK rises at the end of this cycle
//   fall_o   SCK falls at the end of this cycle
module i2s_tx_clkgen #(
  parameter int CLK_DIV_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [CLK_DIV_WIDTH-1:0] div_i,
  output logic                     sck_o,
  output logic                     rise_o,
  output logic                     fall_o
);

  localparam logic [CLK_DIV_WIDTH-1:0] CNT_ONE = CLK_DIV_WIDTH'(1);

  logic [CLK_DIV_WIDTH-1:0] r_cnt;
  logic                     r_sck;
  logic                     w_tc;

  assign w_tc = en_i && (r_cnt == div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!en_i) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign sck_o  = r_sck;
  assign rise_o = w_tc & ~r_sck;
  assign fall_o = w_tc &  r_sck;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx
//   Single-channel I2S master transmitter. Pulls 32-bit samples from the TX
//   FIFO into a one-entry holding buffer, moves them into a shifter at each
//   slot start and drives SD on SCK fall events, MSB- or LSB-first.
//   WS toggles together with the first bit of each slot (left-justified).
// Ports
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   cfg_en_i           channel enable (low = idle and flushed)
//   cfg_clk_div_i      SCK half-period minus 1
//   cfg_bits_word_i    bits per slot minus 1
//   cfg_lsbfirst_i     1 = bit 0 goes out first
//   fifo_data_i/valid_i, fifo_ready_o   TX FIFO handshake
//   underrun_clr_i, underrun_o          sticky underrun flag and its clear
//   ext_sck_o, ext_ws_o, ext_sd_o       I2S pins
//
// state       | meaning
// I2S_TX_IDLE | channel disabled, outputs parked low, buffer flushed
// I2S_TX_RUN  | SCK running, slots transmitted from the holding buffer
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_en_i,
  input  logic [CLK_DIV_WIDTH-1:0] cfg_clk_div_i,
  input  logic [4:0]               cfg_bits_word_i,
  input  logic                     cfg_lsbfirst_i,
  input  logic [31:0]              fifo_data_i,
  input  logic                     fifo_valid_i,
  output logic                     fifo_ready_o,
  input  logic                     underrun_clr_i,
  output logic                     underrun_o,
  output logic                     ext_sck_o,
  output logic                     ext_ws_o,
  output logic                     ext_sd_o
);

  localparam logic [I2S_BITCNT_W-1:0] BIT_ONE = I2S_BITCNT_W'(1);
  localparam logic [I2S_BITCNT_W-1:0] MAX_IDX = I2S_BITCNT_W'(I2S_WORD_W - 1);

  i2s_tx_state_e           r_state;
  i2s_tx_state_e           w_state_nxt;
  logic                    w_enter;
  logic                    w_active;

  logic                    w_sck;
  logic                    w_rise;
  logic                    w_fall;

  logic [I2S_WORD_W-1:0]   r_buf;
  logic                    r_buf_full;
  logic [I2S_WORD_W-1:0]   r_shift;
  logic [I2S_BITCNT_W-1:0] r_bitcnt;
  logic [I2S_BITCNT_W-1:0] r_nm1;
  logic                    r_lsb;
  logic                    r_first;
  logic                    r_ws;
  logic                    r_sd;
  logic                    r_underrun;

  logic                    w_capture;
  logic                    w_slot_start;
  logic [I2S_WORD_W-1:0]   w_load_word;
  logic [I2S_WORD_W-1:0]   w_msb_aligned;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= I2S_TX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    case (r_state)
      I2S_TX_IDLE: begin
        if (cfg_en_i) begin
          w_state_nxt = I2S_TX_RUN;
          w_enter     = 1'b1;
        end
      end
      I2S_TX_RUN: begin
        if (!cfg_en_i) w_state_nxt = I2S_TX_IDLE;
      end
      default: w_state_nxt = I2S_TX_IDLE;
    endcase
  end

  // Dropping cfg_en_i while in RUN must flush everything on the very next
  // edge, so the datapath and divider are gated by the live enable as well.
  assign w_active = (r_state == I2S_TX_RUN) && cfg_en_i;

  // ---------------------------------------------------------------- SCK
  i2s_tx_clkgen #(
    .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
  ) u_clkgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_active),
    .div_i  (cfg_clk_div_i),
    .sck_o  (w_sck),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  // ---------------------------------------------------------------- datapath
  assign fifo_ready_o = (r_state == I2S_TX_RUN) && !r_buf_full;
  assign w_capture    = fifo_valid_i && fifo_ready_o;
  assign w_slot_start = w_fall && (r_first || (r_bitcnt == r_nm1));
  assign w_load_word  = r_buf_full ? r_buf : '0;
  // MSB-first: push bit N-1 to the top so the shifter always emits bit 31.
  assign w_msb_aligned = w_load_word << (MAX_IDX - cfg_bits_word_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_nm1      <= '0;
      r_lsb      <= 1'b0;
      r_first    <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
    end else if (!w_active) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_nm1      <= '0;
      r_lsb      <= 1'b0;
      r_first    <= w_enter;
      r_ws       <= w_enter;
      r_sd       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_buf      <= fifo_data_i;
        r_buf_full <= 1'b1;
      end
      if (w_slot_start) begin
        r_first  <= 1'b0;
        r_ws     <= ~r_ws;
        r_nm1    <= cfg_bits_word_i;
        r_lsb    <= cfg_lsbfirst_i;
        r_bitcnt <= '0;
        if (r_buf_full) r_buf_full <= 1'b0;
        if (cfg_lsbfirst_i) begin
          r_sd    <= w_load_word[0];
          r_shift <= w_load_word >> 1;
        end else begin
          r_sd    <= w_msb_aligned[I2S_WORD_W-1];
          r_shift <= w_msb_aligned << 1;
        end
      end else if (w_fall) begin
        r_bitcnt <= r_bitcnt + BIT_ONE;
        if (r_lsb) begin
          r_sd    <= r_shift[0];
          r_shift <= r_shift >> 1;
        end else begin
          r_sd    <= r_shift[I2S_WORD_W-1];
          r_shift <= r_shift << 1;
        end
      end
    end
  end

  // Sticky; only rst_i clears it besides the explicit clear, and a new
  // underrun in the same cycle as the clear keeps it set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   r_underrun <= 1'b0;
    else if (w_slot_start && !r_buf_full)        r_underrun <= 1'b1;
    else if (underrun_clr_i)                     r_underrun <= 1'b0;
  end

  assign underrun_o = r_underrun;
  assign ext_sck_o  = w_sck;
  assign ext_ws_o   = r_ws;
  assign ext_sd_o   = r_sd;

  logic w_unused;
  assign w_unused = w_rise;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [10:0] cfg_clk_div_i = 11'd0;
  logic [4:0]  cfg_bits_word_i = 5'd0;
  logic        cfg_lsbfirst_i = 1'b0;
  logic [31:0] fifo_data_i = 32'h0;
  logic        fifo_valid_i = 1'b0;
  logic        fifo_ready_o;
  logic        underrun_clr_i = 1'b0;
  logic        underrun_o;
  logic        ext_sck_o, ext_ws_o, ext_sd_o;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV_WIDTH(11)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_clk_div_i   (cfg_clk_div_i),
    .cfg_bits_word_i (cfg_bits_word_i),
    .cfg_lsbfirst_i  (cfg_lsbfirst_i),
    .fifo_data_i     (fifo_data_i),
    .fifo_valid_i    (fifo_valid_i),
    .fifo_ready_o    (fifo_ready_o),
    .underrun_clr_i  (underrun_clr_i),
    .underrun_o      (underrun_o),
    .ext_sck_o       (ext_sck_o),
    .ext_ws_o        (ext_ws_o),
    .ext_sd_o        (ext_sd_o)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          mon_skip = 0;
  int          last_rise = -1;
  int          exp_period = 0;
  int          n_xfer = 0;
  logic        sck_q = 1'b0;
  logic [1:0]  exp_q[$];   // {ws, sd} expected at each SCK rise
  logic [31:0] fifo_q[$];  // words presented by the FIFO model

  // One clk cycle: observe pins at negedge, drive FIFO, let the edge pass.
  task automatic step();
    logic       hs;
    logic [1:0] e;
    @(negedge clk);
    if (ext_sck_o && !sck_q) begin
      if (last_rise >= 0) begin
        n_checks++;
        if ((cyc - last_rise) != exp_period) begin
          n_fails++;
          $display("FAIL sck_period: got %0d cycles, expected %0d", cyc - last_rise, exp_period);
        end
      end
      last_rise = cyc;
      if (mon_skip > 0) mon_skip--;
      else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({ext_ws_o, ext_sd_o} !== e) begin
          n_fails++;
          $display("FAIL slot_bit: ws,sd=%b,%b expected %b,%b (%0d bits left)",
                   ext_ws_o, ext_sd_o, e[1], e[0], exp_q.size());
        end
      end
    end
    sck_q = ext_sck_o;
    cyc++;
    fifo_valid_i = (fifo_q.size() > 0);
    fifo_data_i  = fifo_valid_i ? fifo_q[0] : 32'h0;
    hs = fifo_valid_i && fifo_ready_o;
    @(posedge clk);
    if (hs) begin
      void'(fifo_q.pop_front());
      n_xfer++;
    end
    #1;
  endtask

  task automatic push_slot(input logic [31:0] word, input int n, input logic lsb, input logic ws);
    for (int i = 0; i < n; i++) exp_q.push_back({ws, word[lsb ? i : n - 1 - i]});
  endtask

  task automatic enable();
    mon_skip  = 1;   // first rise precedes the first slot
    last_rise = -1;
    cfg_en_i  = 1'b1;
  endtask

  task automatic run_until_empty(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL %s timeout: %0d bits not seen, expected 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    cfg_en_i = 1'b0;
    underrun_clr_i = 1'b0;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    step();
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    step();
    n_checks++;
    if ({ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o, underrun_o} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: sck,ws,sd,ready,underrun=%b expected 00000",
               {ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o, underrun_o});
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_msb16();
    do_reset();
    cfg_clk_div_i = 11'd1; cfg_bits_word_i = 5'd15; cfg_lsbfirst_i = 1'b0; exp_period = 4;
    fifo_q.push_back(32'h0000A5C3);
    fifo_q.push_back(32'h00001234);
    push_slot(32'h0000A5C3, 16, 1'b0, 1'b0);
    push_slot(32'h00001234, 16, 1'b0, 1'b1);
    n_xfer = 0;
    enable();
    run_until_empty(400, "msb16");
    n_checks++;
    if (n_xfer != 2) begin
      n_fails++;
      $display("FAIL msb16_transfers: got %0d, expected 2", n_xfer);
    end
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fails++;
      $display("FAIL msb16_no_underrun: got %b, expected 0", underrun_o);
    end
    cfg_en_i = 1'b0;
    step();
  endtask

  task automatic test_lsb8();
    do_reset();
    cfg_clk_div_i = 11'd0; cfg_bits_word_i = 5'd7; cfg_lsbfirst_i = 1'b1; exp_period = 2;
    fifo_q.push_back(32'hFFFFFF81);
    push_slot(32'hFFFFFF81, 8, 1'b1, 1'b0);
    push_slot(32'h00000000, 8, 1'b1, 1'b1);
    enable();
    run_until_empty(200, "lsb8");
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fails++;
      $display("FAIL lsb8_second_slot_underrun: got %b, expected 1", underrun_o);
    end
    cfg_en_i = 1'b0;
    step();
  endtask

  task automatic test_underrun();
    do_reset();
    cfg_clk_div_i = 11'd3; cfg_bits_word_i = 5'd31; cfg_lsbfirst_i = 1'b0; exp_period = 8;
    push_slot(32'h0, 32, 1'b0, 1'b0);
    push_slot(32'h0, 32, 1'b0, 1'b1);
    enable();
    step();                                  // now in first RUN cycle (0)
    for (int i = 0; i < 7; i++) step();      // now in cycle 7
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fails++;
      $display("FAIL underrun_before_slot: got %b, expected 0", underrun_o);
    end
    step();                                  // cycle 8, first slot started
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fails++;
      $display("FAIL underrun_first_slot: got %b, expected 1", underrun_o);
    end
    for (int i = 0; i < 92; i++) step();     // cycle 100
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fails++;
      $display("FAIL underrun_clear: got %b, expected 0", underrun_o);
    end
    for (int i = 0; i < 162; i++) step();    // cycle 263: second slot start
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fails++;
      $display("FAIL underrun_set_wins: got %b, expected 1", underrun_o);
    end
    run_until_empty(600, "underrun");
    cfg_en_i = 1'b0;
    step();
  endtask

  task automatic test_disable();
    logic [31:0] w1;
    w1 = 32'h00ABCDEF;
    do_reset();
    cfg_clk_div_i = 11'd1; cfg_bits_word_i = 5'd23; cfg_lsbfirst_i = 1'b0; exp_period = 4;
    fifo_q.push_back(w1);
    fifo_q.push_back(32'h00123456);
    fifo_q.push_back(32'h00654321);
    for (int i = 0; i < 11; i++) exp_q.push_back({1'b0, w1[23 - i]});
    enable();
    run_until_empty(200, "disable_prefix");
    cfg_en_i = 1'b0;
    step();
    n_checks++;
    if ({ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o} !== 4'b0) begin
      n_fails++;
      $display("FAIL disable_outputs: sck,ws,sd,ready=%b expected 0000",
               {ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o});
    end
    n_checks++;
    if (fifo_q.size() != 1) begin
      n_fails++;
      $display("FAIL disable_fifo_level: got %0d words left, expected 1", fifo_q.size());
    end
    exp_q.delete();
    step();
    push_slot(32'h00654321, 24, 1'b0, 1'b0);
    enable();
    run_until_empty(300, "reenable");
    cfg_en_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_clk_div_i = 11'd0; cfg_bits_word_i = 5'd7; cfg_lsbfirst_i = 1'b0; exp_period = 2;
    enable();
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_mid_precondition: underrun=%b expected 1", underrun_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o, underrun_o} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_mid_async: sck,ws,sd,ready,underrun=%b expected 00000",
               {ext_sck_o, ext_ws_o, ext_sd_o, fifo_ready_o, underrun_o});
    end
    cfg_en_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_width_change();
    logic [31:0] w1;
    w1 = 32'h0000BEEF;
    do_reset();
    cfg_clk_div_i = 11'd0; cfg_bits_word_i = 5'd15; cfg_lsbfirst_i = 1'b0; exp_period = 2;
    fifo_q.push_back(w1);
    fifo_q.push_back(32'h89ABCDEF);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, w1[15 - i]});
    enable();
    run_until_empty(100, "width_prefix");
    cfg_bits_word_i = 5'd31;
    for (int i = 5; i < 16; i++) exp_q.push_back({1'b0, w1[15 - i]});
    push_slot(32'h89ABCDEF, 32, 1'b0, 1'b1);
    run_until_empty(300, "width_change");
    cfg_en_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_msb16();
    test_lsb8();
    test_underrun();
    test_disable();
    test_reset_mid();
    test_width_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
